// File: rtl/vga_pkg.sv
// Shared VGA definitions: pixel format, default colours, 800x600 active area
// and the timing-bus sideband layout carried alongside each pixel.
package vga_pkg;

    localparam int unsigned VGA_RGB_W    = 12;
    localparam int unsigned VGA_HCNT_W   = 11;
    localparam int unsigned VGA_VCNT_W   = 11;
    localparam int unsigned VGA_H_ACTIVE = 800;
    localparam int unsigned VGA_V_ACTIVE = 600;

    localparam logic [VGA_RGB_W-1:0] VGA_TRANSPARENT_KEY = 12'hF0F;
    localparam logic [VGA_RGB_W-1:0] VGA_BG_RGB          = 12'h000;
    localparam logic [VGA_RGB_W-1:0] VGA_WHITE           = 12'hFFF;

    // Timing sideband that travels in lockstep with the pixel pipeline
    typedef struct packed {
        logic [VGA_HCNT_W-1:0] hcount;
        logic [VGA_VCNT_W-1:0] vcount;
        logic                  hsync;
        logic                  vsync;
        logic                  hblnk;
        logic                  vblnk;
    } vga_side_t;

    localparam int unsigned VGA_SIDE_W = $bits(vga_side_t);

endpackage

// File: rtl/vga_layer_mixer_if.sv
// Incoming VGA timing bus (counters, syncs, blanks) shared by all layer sources.
interface vga_layer_mixer_if;
    import vga_pkg::*;

    logic [VGA_HCNT_W-1:0] hcount_in;
    logic [VGA_VCNT_W-1:0] vcount_in;
    logic                  hsync_in;
    logic                  vsync_in;
    logic                  hblnk_in;
    logic                  vblnk_in;

    modport master (
        output hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in
    );

    modport slave (
        input hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in
    );

endinterface

// File: rtl/vga_delay_line.sv
// Generic reset-to-zero register delay; every stage is exposed on taps so the
// consumer can pick the alignment it needs (stage d at [d*WIDTH +: WIDTH]).
module vga_delay_line #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         din,
    output logic [DEPTH*WIDTH-1:0]   taps
);

    logic [DEPTH-1:0][WIDTH-1:0] stage;

    // Shift register, stage 0 samples din
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage <= '0;
        end else begin
            stage[0] <= din;
            for (int d = 1; d < DEPTH; d++) begin
                stage[d] <= stage[d-1];
            end
        end
    end

    assign taps = stage;

endmodule

// File: rtl/vga_layer_mixer.sv
// Fixed-priority N-layer RGB compositor with colour-key transparency and
// frame-synchronous layer enables. Latency is 3 pclk for pixel and syncs.
// Optional build macro: VGA_MIX_DEBUG_BORDER_EN forces a white 1-pixel border.
module vga_layer_mixer
    import vga_pkg::*;
#(
    parameter int unsigned           N_LAYERS        = 4,
    parameter int unsigned           RGB_W           = VGA_RGB_W,
    parameter logic [RGB_W-1:0]      TRANSPARENT_KEY = VGA_TRANSPARENT_KEY,
    parameter logic [RGB_W-1:0]      BG_RGB          = VGA_BG_RGB,
    parameter int unsigned           H_ACTIVE        = VGA_H_ACTIVE,
    parameter int unsigned           V_ACTIVE        = VGA_V_ACTIVE
) (
    input  logic                        pclk,
    input  logic                        rst_n,
    vga_layer_mixer_if.slave            tim,
    input  logic [N_LAYERS*RGB_W-1:0]   layer_rgb,
    input  logic [N_LAYERS-1:0]         layer_en,
    output logic                        hs,
    output logic                        vs,
    output logic [3:0]                  r,
    output logic [3:0]                  g,
    output logic [3:0]                  b,
    output logic                        frame_start
);

    localparam int unsigned SIDE_DEPTH = 3;

    // Elaboration-time parameter sanity
    if (N_LAYERS < 2 || N_LAYERS > 8) begin : g_bad_layers
        $error("vga_layer_mixer: N_LAYERS must be in 2..8");
    end
    if (RGB_W != 12) begin : g_bad_rgb_w
        $error("vga_layer_mixer: RGB_W must be 12 for the 4:4:4 split");
    end
    if (H_ACTIVE == 0 || V_ACTIVE == 0) begin : g_bad_active
        $error("vga_layer_mixer: active area must be non-zero");
    end

    vga_side_t                      side_in;
    vga_side_t                      s1_side;
    vga_side_t                      s2_side;
    vga_side_t                      s3_side;
    logic [SIDE_DEPTH*VGA_SIDE_W-1:0] side_taps;

    logic [N_LAYERS*RGB_W-1:0]      s1_rgb;
    logic [N_LAYERS-1:0]            shadow_en;
    logic                           vblnk_armed;
    logic                           vblnk_rise_c;
    logic [RGB_W-1:0]               sel_c;
    logic [RGB_W-1:0]               s2_rgb;
    logic [RGB_W-1:0]               s3_rgb;
    logic                           unused_side_bits;

    assign side_in = '{
        hcount: tim.hcount_in,
        vcount: tim.vcount_in,
        hsync:  tim.hsync_in,
        vsync:  tim.vsync_in,
        hblnk:  tim.hblnk_in,
        vblnk:  tim.vblnk_in
    };

    vga_delay_line #(
        .WIDTH (VGA_SIDE_W),
        .DEPTH (SIDE_DEPTH)
    ) u_side_dly (
        .clk   (pclk),
        .rst_n (rst_n),
        .din   (side_in),
        .taps  (side_taps)
    );

    assign s1_side = side_taps[0*VGA_SIDE_W +: VGA_SIDE_W];
    assign s2_side = side_taps[1*VGA_SIDE_W +: VGA_SIDE_W];
    assign s3_side = side_taps[2*VGA_SIDE_W +: VGA_SIDE_W];

    // Sideband fields that no stage consumes at that alignment
    assign unused_side_bits = ^{s1_side.hcount, s1_side.vcount, s1_side.hsync,
                                s1_side.vsync, s2_side.hcount, s2_side.vcount,
                                s2_side.hsync, s2_side.vsync, s3_side.hcount,
                                s3_side.vcount, s3_side.hblnk, s3_side.vblnk};

    // First edge after reset only primes the history, so a vblank already in
    // progress at reset release is not mistaken for a frame start
    assign vblnk_rise_c = vblnk_armed & tim.vblnk_in & ~s1_side.vblnk;

    // S1: capture layer pixels, track vblank start, latch shadow enables
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            s1_rgb      <= '0;
            shadow_en   <= '1;
            vblnk_armed <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            s1_rgb      <= layer_rgb;
            vblnk_armed <= 1'b1;
            frame_start <= vblnk_rise_c;
            if (vblnk_rise_c) begin
                shadow_en <= layer_en;
            end
        end
    end

    // S2 select: highest enabled, non-keyed layer wins; later iterations override
    always_comb begin
        sel_c = BG_RGB;
        for (int k = 0; k < int'(N_LAYERS); k++) begin
            if (shadow_en[k] && (s1_rgb[k*RGB_W +: RGB_W] != TRANSPARENT_KEY)) begin
                sel_c = s1_rgb[k*RGB_W +: RGB_W];
            end
        end
`ifdef VGA_MIX_DEBUG_BORDER_EN
        if ((s1_side.hcount == VGA_HCNT_W'(0)) ||
            (s1_side.hcount == VGA_HCNT_W'(H_ACTIVE - 1)) ||
            (s1_side.vcount == VGA_VCNT_W'(0)) ||
            (s1_side.vcount == VGA_VCNT_W'(V_ACTIVE - 1))) begin
            sel_c = VGA_WHITE;
        end
`endif
    end

    // S2 register, then S3 output register with blanking
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            s2_rgb <= '0;
            s3_rgb <= '0;
        end else begin
            s2_rgb <= sel_c;
            s3_rgb <= (s2_side.hblnk | s2_side.vblnk) ? '0 : s2_rgb;
        end
    end

    assign hs = s3_side.hsync;
    assign vs = s3_side.vsync;
    assign r  = s3_rgb[11:8];
    assign g  = s3_rgb[7:4];
    assign b  = s3_rgb[3:0];

endmodule

// File: tb/tb_vga_layer_mixer.sv
// Directed bench for vga_layer_mixer: latency, priority, keying, blanking,
// shadowed enables, async reset and the optional debug border.
module tb_vga_layer_mixer;
    import vga_pkg::*;

    localparam int unsigned N = 4;

    logic              pclk = 1'b0;
    logic              rst_n;
    logic [N*12-1:0]   layer_rgb;
    logic [N-1:0]      layer_en;
    logic              hs, vs, frame_start;
    logic [3:0]        r, g, b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 pclk = ~pclk;

    vga_layer_mixer_if tim ();

    vga_layer_mixer #(.N_LAYERS(N)) dut (
        .pclk        (pclk),
        .rst_n       (rst_n),
        .tim         (tim),
        .layer_rgb   (layer_rgb),
        .layer_en    (layer_en),
        .hs          (hs),
        .vs          (vs),
        .r           (r),
        .g           (g),
        .b           (b),
        .frame_start (frame_start)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge pclk);
    endtask

    task automatic set_layers(input logic [11:0] l3, input logic [11:0] l2,
                              input logic [11:0] l1, input logic [11:0] l0);
        layer_rgb = {l3, l2, l1, l0};
    endtask

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %03h expected %03h", tag, obs, exp);
        end
    endtask

    logic [11:0] exp_border;

    initial begin
`ifdef VGA_MIX_DEBUG_BORDER_EN
        exp_border = 12'hFFF;
`else
        exp_border = 12'h123;
`endif
        rst_n         = 1'b0;
        tim.hcount_in = 11'd100;
        tim.vcount_in = 11'd100;
        tim.hsync_in  = 1'b1;
        tim.vsync_in  = 1'b0;
        tim.hblnk_in  = 1'b0;
        tim.vblnk_in  = 1'b0;
        layer_en      = 4'b1111;
        set_layers(12'hF0F, 12'hF0F, 12'hF0F, 12'h123);

        // Reset state
        tick(5);
        chk("rst_rgb", {r, g, b}, 12'h000);
        chk("rst_hs", 12'(hs), 12'h0);
        chk("rst_vs", 12'(vs), 12'h0);
        chk("rst_fs", 12'(frame_start), 12'h0);

        // Latency after release
        rst_n = 1'b1;
        tick(1);
        chk("lat1_rgb", {r, g, b}, 12'h000);
        chk("lat1_hs", 12'(hs), 12'h0);
        tick(1);
        chk("lat2_rgb", {r, g, b}, 12'h000);
        chk("lat2_hs", 12'(hs), 12'h0);
        tick(1);
        chk("lat3_rgb", {r, g, b}, 12'h123);
        chk("lat3_hs", 12'(hs), 12'h1);
        chk("lat3_vs", 12'(vs), 12'h0);

        // Priority and colour key
        set_layers(12'hABC, 12'hF0F, 12'h456, 12'h123);
        tick(3);
        chk("prio_top", {r, g, b}, 12'hABC);
        set_layers(12'hF0F, 12'hF0F, 12'h456, 12'h123);
        tick(2);
        chk("prio_hold", {r, g, b}, 12'hABC);
        tick(1);
        chk("prio_key3", {r, g, b}, 12'h456);
        set_layers(12'hF0F, 12'hF0F, 12'hF0F, 12'hF0F);
        tick(3);
        chk("prio_bg", {r, g, b}, 12'h000);

        // Blanking keeps syncs flowing
        set_layers(12'hF0F, 12'hF0F, 12'hF0F, 12'hFFF);
        tim.hblnk_in = 1'b1;
        tim.hsync_in = 1'b0;
        tick(3);
        chk("blank_rgb", {r, g, b}, 12'h000);
        chk("blank_hs0", 12'(hs), 12'h0);
        tim.hsync_in = 1'b1;
        tick(3);
        chk("blank_rgb2", {r, g, b}, 12'h000);
        chk("blank_hs1", 12'(hs), 12'h1);
        tim.hblnk_in = 1'b0;
        tick(3);
        chk("unblank_rgb", {r, g, b}, 12'hFFF);

        // Shadowed enables: mid-frame change ignored, vblank-edge change captured
        set_layers(12'hABC, 12'hF0F, 12'h456, 12'h123);
        layer_en = 4'b0011;
        tick(3);
        chk("shadow_mid", {r, g, b}, 12'hABC);
        chk("shadow_fs0", 12'(frame_start), 12'h0);
        tick(2);
        chk("shadow_mid2", {r, g, b}, 12'hABC);
        tim.vblnk_in = 1'b1;
        layer_en     = 4'b0001;
        tick(1);
        chk("fs_pulse", 12'(frame_start), 12'h1);
        tick(1);
        chk("fs_single", 12'(frame_start), 12'h0);
        tick(1);
        chk("vblank_rgb", {r, g, b}, 12'h000);
        layer_en     = 4'b1111;
        tim.vblnk_in = 1'b0;
        tick(3);
        chk("new_frame_l0", {r, g, b}, 12'h123);
        chk("new_frame_fs", 12'(frame_start), 12'h0);

        // Debug border
        tim.vsync_in  = 1'b1;
        tim.hcount_in = 11'd799;
        tim.vcount_in = 11'd300;
        tick(3);
        chk("border_h799", {r, g, b}, exp_border);
        tim.hcount_in = 11'd400;
        tick(3);
        chk("border_h400", {r, g, b}, 12'h123);
        tim.vcount_in = 11'd599;
        tick(3);
        chk("border_v599", {r, g, b}, exp_border);
        tim.vcount_in = 11'd300;
        tick(3);
        chk("pre_rst_hs", 12'(hs), 12'h1);
        chk("pre_rst_vs", 12'(vs), 12'h1);
        chk("pre_rst_rgb", {r, g, b}, 12'h123);

        // Async reset between edges, with vblank already high at release
        @(posedge pclk);
        #2;
        rst_n        = 1'b0;
        tim.vblnk_in = 1'b1;
        layer_en     = 4'b0001;
        #1;
        chk("arst_rgb", {r, g, b}, 12'h000);
        chk("arst_hs", 12'(hs), 12'h0);
        chk("arst_vs", 12'(vs), 12'h0);
        chk("arst_fs", 12'(frame_start), 12'h0);
        tick(2);
        set_layers(12'hABC, 12'hF0F, 12'hF0F, 12'h123);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            chk("no_fs_after_rst", 12'(frame_start), 12'h0);
        end
        chk("rst_vblank_rgb", {r, g, b}, 12'h000);
        tim.vblnk_in = 1'b0;
        tick(3);
        chk("shadow_rst_ones", {r, g, b}, 12'hABC);
        tim.vblnk_in = 1'b1;
        tick(1);
        chk("fs_after_rst", 12'(frame_start), 12'h1);
        tick(1);
        chk("fs_after_rst_end", 12'(frame_start), 12'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
